reg_read_port: RTL and testbench
================================

Name: reg_read_port

Overview:
- Read side of the 8-entry, 16-bit register file (wr, ma, ar, na, rv, sp, ra, tp), which has a write port only.
- Two requesters share one read path: req0 (decode/operand fetch) and req1 (stack/call unit).
- Round-robin arbitration, write-to-read forwarding from the same-cycle write port, and a small response FIFO so the consumer can apply backpressure.
- Sits between the register file outputs and the datapath consumers.

Parameters:
- FIFO_DEPTH, 2, response FIFO entries; power of two, minimum 2.
- DATA_W, 16, register width; fixed at 16.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- wr, ma, ar, na, rv, sp, ra, tp  input  16 each  current register file outputs; index order 0..7.
- regWrite  input  1  register file write enable for this cycle.
- regDest  input  3  register file write index for this cycle.
- DataWrite  input  16  register file write data for this cycle.
- req0_valid  input  1  requester 0 read request.
- req0_addr  input  3  requester 0 register index.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req1_valid  input  1  requester 1 read request.
- req1_addr  input  3  requester 1 register index.
- req1_ready  output  1  requester 1 request accepted this cycle.
- rsp_valid  output  1  head of response FIFO is valid.
- rsp_data  output  16  read data.
- rsp_src  output  1  requester id of the response (0 or 1).
- rsp_addr  output  3  register index of the response.
- rsp_ready  input  1  consumer accepts the response.

Behaviour:
- Reset (RST high at a clock edge):
  - FIFO count = 0; rsp_valid = 0; rsp_data = 0; rsp_src = 0; rsp_addr = 0.
  - last_grant = 1, so req0 wins the first contention.
  - RST overrides any same-cycle push or pop; in-flight entries are discarded.
- Acceptance:
  - space = (count < FIFO_DEPTH). rsp_ready does not feed into space, so there is no combinational path from rsp_ready to reqN_ready.
  - Only one requester has its valid asserted: grant it if space.
  - Both requesters have valid asserted: grant the one not equal to last_grant, if space.
  - reqN_ready = grant_N & space. This is combinational from reqN_valid and state.
  - At most one ready is high per cycle. The loser's ready stays 0, and its request must be held stable until accepted.
  - On acceptance, last_grant takes the granted id.
- Read data captured at acceptance:
  - sel = granted addr. Base value = register bus[sel].
  - Forwarding: if regWrite && regDest == sel, the captured data is DataWrite. The register file updates only at the edge, so forwarding is required to return the post-write value.
  - The pushed entry is {data, src, addr}.
- Response timing:
  - Latency from acceptance to rsp_valid is 1 cycle when the FIFO is empty.
  - Responses are in acceptance order.
  - rsp_* hold stable while rsp_valid && !rsp_ready.
  - Pop happens on rsp_valid && rsp_ready.
- FIFO rules:
  - Push and pop in the same cycle: count unchanged.
  - Push while full cannot occur, because ready is gated.
  - Pop while empty cannot occur, because rsp_valid = 0.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - When the FIFO becomes empty, rsp_data/src/addr keep their last value; this is don't-care to the consumer.
- Throughput: one read accepted per cycle while the consumer keeps up. When full, the ready lines reopen the cycle after a pop.

Optional Feature:
- Macro: REG_READ_FWD_EN.
- Defined: same-cycle write-to-read forwarding exactly as in Behaviour.
- Undefined: captured data is always register bus[sel], the pre-write value. No regWrite/regDest/DataWrite logic is instantiated; those ports remain but are unused.

Test Plan:
- Reset then single read: set ar = 16'h1234; req0_valid = 1, addr = 2 for one cycle. Expect req0_ready = 1 that cycle; next cycle rsp_valid = 1, rsp_data = 16'h1234, rsp_src = 0, rsp_addr = 2.
- Contention: both requesters valid continuously, req0 addr = 5 (sp = 16'h0FFF), req1 addr = 6 (ra = 16'h0042), rsp_ready = 1. Expect grants 0,1,0,1 and responses alternating 0FFF/0042 with src 0/1.
- Forwarding: req1 reads addr 4 (rv = 16'h0000) in the same cycle as regWrite = 1, regDest = 4, DataWrite = 16'hBEEF. With REG_READ_FWD_EN, rsp_data = 16'hBEEF; without it, 16'h0000. Same setup with regDest = 3: rsp_data = 16'h0000 in both builds.
- Backpressure: rsp_ready = 0, req0 streams reads of addr 0..3. Expect exactly FIFO_DEPTH (2) acceptances, then req0_ready = 0. Raising rsp_ready drains the responses in order addr 0, 1; acceptance resumes with addr 2 the cycle after the first pop.
- Simultaneous push/pop: FIFO holds 1 entry, rsp_ready = 1, new request accepted the same cycle. Expect count to stay 1 and no response to be lost or duplicated.
- Reset mid-operation: FIFO full, assert RST for one cycle. Next cycle rsp_valid = 0 and req0_ready = 1 for a pending req0. Under contention, req0 wins first.

Source files
------------

// File: rtl/reg_read_port.sv
// Two-requester round-robin read port for the 8x16 register file, with a small
// in-order response FIFO. Optional write-to-read forwarding: REG_READ_FWD_EN.
module reg_read_port #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DATA_W     = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] wr,
    input  logic [DATA_W-1:0] ma,
    input  logic [DATA_W-1:0] ar,
    input  logic [DATA_W-1:0] na,
    input  logic [DATA_W-1:0] rv,
    input  logic [DATA_W-1:0] sp,
    input  logic [DATA_W-1:0] ra,
    input  logic [DATA_W-1:0] tp,
    input  logic              regWrite,
    input  logic [2:0]        regDest,
    input  logic [DATA_W-1:0] DataWrite,
    input  logic              req0_valid,
    input  logic [2:0]        req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [2:0]        req1_addr,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_src,
    output logic [2:0]        rsp_addr,
    input  logic              rsp_ready
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              src;
        logic [2:0]        addr;
    } entry_t;

    entry_t            mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr, rdPtr, headIdx;
    logic [PTR_W:0]    count;
    logic              lastGrant;

    logic [DATA_W-1:0] regBus [8];
    logic              grant0, grant1, space, push, pop;
    logic [2:0]        sel;
    logic [DATA_W-1:0] pushData;

    assign regBus[0] = wr;
    assign regBus[1] = ma;
    assign regBus[2] = ar;
    assign regBus[3] = na;
    assign regBus[4] = rv;
    assign regBus[5] = sp;
    assign regBus[6] = ra;
    assign regBus[7] = tp;

    // rsp_ready is deliberately excluded from space: no comb path rsp_ready -> reqN_ready.
    assign space = (count < DEPTH_C);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (lastGrant) grant0 = 1'b1;
            else           grant1 = 1'b1;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = grant0 & space;
    assign req1_ready = grant1 & space;
    assign push       = req0_ready | req1_ready;
    assign sel        = grant1 ? req1_addr : req0_addr;

`ifdef REG_READ_FWD_EN
    // The register file only updates at the edge, so a same-cycle write must be bypassed.
    assign pushData = (regWrite && (regDest == sel)) ? DataWrite : regBus[sel];
`else
    logic unusedFwd;
    assign unusedFwd = ^{regWrite, regDest, DataWrite};
    assign pushData  = regBus[sel];
`endif

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;

    // When empty, point at the slot just popped so the outputs keep their last value.
    assign headIdx  = (count == '0) ? (rdPtr - PTR_W'(1)) : rdPtr;
    assign rsp_data = mem[headIdx].data;
    assign rsp_src  = mem[headIdx].src;
    assign rsp_addr = mem[headIdx].addr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count     <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            lastGrant <= 1'b1;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wrPtr] <= '{data: pushData, src: grant1, addr: sel};
                wrPtr      <= wrPtr + PTR_W'(1);
                lastGrant  <= grant1;
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_read_port.sv
// Self-checking bench for reg_read_port: directed scenarios plus a randomized
// run against a queue-based reference model. Honours REG_READ_FWD_EN.
module tb_reg_read_port;

    localparam int DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] rf [8];
    logic        regWrite;
    logic [2:0]  regDest;
    logic [15:0] DataWrite;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [2:0]  req0_addr, req1_addr;
    logic        req0_ready, req1_ready, rsp_valid, rsp_src;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic        src;
        logic [2:0]  addr;
    } rsp_t;
    rsp_t expQ[$];

    always #5 CLK = ~CLK;

    reg_read_port #(.FIFO_DEPTH(DEPTH), .DATA_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .wr(rf[0]), .ma(rf[1]), .ar(rf[2]), .na(rf[3]),
        .rv(rf[4]), .sp(rf[5]), .ra(rf[6]), .tp(rf[7]),
        .regWrite(regWrite), .regDest(regDest), .DataWrite(DataWrite),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_src(rsp_src),
        .rsp_addr(rsp_addr), .rsp_ready(rsp_ready)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr  = '0;   req1_addr  = '0;
        regWrite   = 1'b0; regDest    = '0; DataWrite = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0;
        do_reset();
        #3;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0000", rsp_data); end
        checks++; if (rsp_src !== 1'b0) begin errors++; $display("FAIL reset_rsp_src got %b exp 0", rsp_src); end
        checks++; if (rsp_addr !== 3'd0) begin errors++; $display("FAIL reset_rsp_addr got %0d exp 0", rsp_addr); end
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", req0_ready, req1_ready); end
        tick();
    endtask

    task automatic test_single_read();
        rsp_ready = 1'b1;
        rf[2] = 16'h1234;
        req0_valid = 1'b1; req0_addr = 3'd2;
        #3;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", req0_ready); end
        tick();
        idle();
        #3;
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid got %b exp 1", rsp_valid); end
        checks++; if (rsp_data !== 16'h1234) begin errors++; $display("FAIL single_rsp_data got %h exp 1234", rsp_data); end
        checks++; if (rsp_src !== 1'b0 || rsp_addr !== 3'd2) begin errors++; $display("FAIL single_rsp_tag got src %b addr %0d exp src 0 addr 2", rsp_src, rsp_addr); end
        tick();
        #3;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %b exp 0", rsp_valid); end
        tick();
    endtask

    task automatic test_contention();
        logic        prevSrc;
        logic [15:0] prevData;
        rsp_ready = 1'b1;
        do_reset();
        rf[5] = 16'h0FFF; rf[6] = 16'h0042;
        req0_valid = 1'b1; req0_addr = 3'd5;
        req1_valid = 1'b1; req1_addr = 3'd6;
        for (int i = 0; i < 4; i++) begin
            #3;
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                errors++; $display("FAIL contention_grant[%0d] got %b%b exp %b%b", i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
            end
            if (i > 0) begin
                prevSrc  = ((i - 1) % 2 == 1);
                prevData = prevSrc ? 16'h0042 : 16'h0FFF;
                checks++;
                if (rsp_valid !== 1'b1 || rsp_src !== prevSrc || rsp_data !== prevData) begin
                    errors++; $display("FAIL contention_rsp[%0d] got v%b src %b data %h exp v1 src %b data %h", i, rsp_valid, rsp_src, rsp_data, prevSrc, prevData);
                end
            end
            tick();
        end
        idle();
        #3;
        checks++; if (rsp_valid !== 1'b1 || rsp_src !== 1'b1 || rsp_data !== 16'h0042) begin errors++; $display("FAIL contention_last got v%b src %b data %h exp v1 src 1 data 0042", rsp_valid, rsp_src, rsp_data); end
        tick();
    endtask

    task automatic test_forwarding();
        logic [15:0] expHit;
`ifdef REG_READ_FWD_EN
        expHit = 16'hBEEF;
`else
        expHit = 16'h0000;
`endif
        rsp_ready = 1'b1;
        rf[4] = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            req1_valid = 1'b1; req1_addr = 3'd4;
            regWrite = 1'b1; regDest = (k == 0) ? 3'd4 : 3'd3; DataWrite = 16'hBEEF;
            #3;
            checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready[%0d] got %b exp 1", k, req1_ready); end
            tick();
            idle();
            #3;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== ((k == 0) ? expHit : 16'h0000) || rsp_src !== 1'b1) begin
                errors++; $display("FAIL fwd_data[%0d] got v%b data %h src %b exp v1 data %h src 1", k, rsp_valid, rsp_data, rsp_src, (k == 0) ? expHit : 16'h0000);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] a;
        rsp_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) rf[i] = 16'hA000 + 16'(i);
        a = 3'd0;
        req0_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req0_addr = a;
            #3;
            checks++; if (req0_ready !== (i < DEPTH)) begin errors++; $display("FAIL bp_accept[%0d] got %b exp %b", i, req0_ready, (i < DEPTH)); end
            if (i < DEPTH) a = a + 3'd1;
            tick();
        end
        rsp_ready = 1'b1;
        req0_addr = 3'd2;
        #3;
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL bp_no_comb_path got %b exp 0", req0_ready); end
        checks++; if (rsp_addr !== 3'd0 || rsp_data !== 16'hA000) begin errors++; $display("FAIL bp_head0 got addr %0d data %h exp addr 0 data a000", rsp_addr, rsp_data); end
        tick();
        #3;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen got %b exp 1", req0_ready); end
        checks++; if (rsp_addr !== 3'd1 || rsp_data !== 16'hA001) begin errors++; $display("FAIL bp_head1 got addr %0d data %h exp addr 1 data a001", rsp_addr, rsp_data); end
        tick();
        req0_addr = 3'd3;
        #3;
        checks++; if (req0_ready !== 1'b1 || rsp_addr !== 3'd2) begin errors++; $display("FAIL bp_head2 got ready %b addr %0d exp ready 1 addr 2", req0_ready, rsp_addr); end
        tick();
        idle();
        #3;
        checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 3'd3 || rsp_data !== 16'hA003) begin errors++; $display("FAIL bp_head3 got v%b addr %0d data %h exp v1 addr 3 data a003", rsp_valid, rsp_addr, rsp_data); end
        tick();
        #3;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", rsp_valid); end
        tick();
    endtask

    task automatic test_push_pop();
        rsp_ready = 1'b0;
        rf[1] = 16'h1111; rf[7] = 16'h7777;
        req0_valid = 1'b1; req0_addr = 3'd1;
        #3;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL pp_first_ready got %b exp 1", req0_ready); end
        tick();
        req0_addr = 3'd7; rsp_ready = 1'b1;
        #3;
        checks++; if (req0_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_addr !== 3'd1) begin errors++; $display("FAIL pp_overlap got ready %b v%b addr %0d exp ready 1 v1 addr 1", req0_ready, rsp_valid, rsp_addr); end
        tick();
        idle();
        #3;
        checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 3'd7 || rsp_data !== 16'h7777) begin errors++; $display("FAIL pp_second got v%b addr %0d data %h exp v1 addr 7 data 7777", rsp_valid, rsp_addr, rsp_data); end
        tick();
        #3;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL pp_no_dup got %b exp 0", rsp_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_addr = 3'd0;
        tick();
        tick();
        #3;
        checks++; if (req0_ready !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL rm_full got ready %b v%b exp ready 0 v1", req0_ready, rsp_valid); end
        RST = 1'b1;
        req1_valid = 1'b1; req1_addr = 3'd6;
        tick();
        RST = 1'b0;
        #3;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_flushed got %b exp 0", rsp_valid); end
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rm_req0_first got %b%b exp 10", req0_ready, req1_ready); end
        tick();
        idle();
        rsp_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_random();
        bit          p0v, p1v, mLast, g0, g1, e0, e1, sp;
        logic [2:0]  p0a, p1a, s;
        logic [15:0] d;
        rsp_t        r;
        idle();
        rsp_ready = 1'b0;
        do_reset();
        expQ.delete();
        mLast = 1'b1;
        p0v = 1'b0; p1v = 1'b0; p0a = '0; p1a = '0;
        for (int c = 0; c < 600; c++) begin
            if (!p0v && ($urandom % 3 != 0)) begin p0v = 1'b1; p0a = 3'($urandom); end
            if (!p1v && ($urandom % 3 != 0)) begin p1v = 1'b1; p1a = 3'($urandom); end
            for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
            regWrite  = 1'($urandom);
            regDest   = ($urandom % 2 == 1) ? (p1v ? p1a : p0a) : 3'($urandom);
            DataWrite = 16'($urandom);
            rsp_ready = ((c / 50) % 2 == 1) ? ($urandom % 4 == 0) : ($urandom % 4 != 0);
            req0_valid = p0v; req0_addr = p0a;
            req1_valid = p1v; req1_addr = p1a;
            #3;
            sp = (expQ.size() < DEPTH);
            if (p0v && p1v) begin g0 = mLast; g1 = !mLast; end
            else begin g0 = p0v; g1 = p1v; end
            e0 = g0 && sp; e1 = g1 && sp;
            checks++;
            if (req0_ready !== e0 || req1_ready !== e1) begin
                errors++; $display("FAIL rand_ready[%0d] got %b%b exp %b%b", c, req0_ready, req1_ready, e0, e1);
            end
            checks++;
            if (rsp_valid !== (expQ.size() > 0)) begin
                errors++; $display("FAIL rand_valid[%0d] got %b exp %b", c, rsp_valid, (expQ.size() > 0));
            end else if (expQ.size() > 0) begin
                checks++;
                if (rsp_data !== expQ[0].data || rsp_src !== expQ[0].src || rsp_addr !== expQ[0].addr) begin
                    errors++; $display("FAIL rand_head[%0d] got %h/%b/%0d exp %h/%b/%0d", c, rsp_data, rsp_src, rsp_addr, expQ[0].data, expQ[0].src, expQ[0].addr);
                end
            end
            if (expQ.size() > 0 && rsp_ready) void'(expQ.pop_front());
            if (e0 || e1) begin
                s = e1 ? p1a : p0a;
                d = rf[s];
`ifdef REG_READ_FWD_EN
                if (regWrite && regDest == s) d = DataWrite;
`endif
                r.data = d; r.src = e1; r.addr = s;
                expQ.push_back(r);
                mLast = e1;
                if (e1) p1v = 1'b0; else p0v = 1'b0;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        RST = 1'b0;
        rsp_ready = 1'b0;
        idle();
        for (int i = 0; i < 8; i++) rf[i] = '0;
        tick();
        test_reset();
        test_single_read();
        test_contention();
        test_forwarding();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
